// File: rtl/capture_ctrl.sv
// capture_ctrl: camera capture mode controller (video / freeze-on-frame / clear) and frame-buffer write-port arbiter
module capture_ctrl #(
  parameter int AW = 15,
  parameter int MEM_DEPTH = 19200,
  parameter int DB_CYCLES = 16,
  parameter logic [11:0] CLEAR_DATA = 12'h000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CAM_VSYNC,
  input  logic          Photo_button,
  input  logic          Video_button,
  input  logic          Clear_button,
  input  logic [AW-1:0] cam_addr,
  input  logic [11:0]   cam_data,
  input  logic          cam_regW,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [11:0]   DP_RAM_data_in,
  output logic          DP_RAM_regW,
  output logic          cam_enable,
  output logic          frame_done,
  output logic [7:0]    frame_cnt,
  output logic [1:0]    mode
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  typedef enum logic [1:0] {VIDEO, PEND, PHOTO, CLEAR} state_t;
  state_t state, state_n, ret, ret_n;
  // button vectors are ordered {clear, video, photo}
  logic [2:0] btn, s1, s2, db, db_d, ev;
  logic [CW-1:0] cnt [3];
  logic vs_prev, vs_rise, clr_last, live;
  logic [AW-1:0] clr_addr;
  assign btn = {Clear_button, Video_button, Photo_button};
  assign vs_rise = CAM_VSYNC & ~vs_prev;
  assign clr_last = clr_addr == AW'(MEM_DEPTH - 1);
  assign live = (state == VIDEO) || (state == PEND);
  assign cam_enable = live;
  assign mode = state;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      db_d <= '0;
      ev <= '0;
      cnt <= '{default: '0};
    end else begin
      s1 <= btn;
      s2 <= s1;
      db_d <= db;
      ev <= db & ~db_d;
      for (int k = 0; k < 3; k++) begin
        cnt[k] <= (s2[k] == db[k] || cnt[k] == CW'(DB_CYCLES - 1)) ? '0 : cnt[k] + 1'b1;
        if (s2[k] != db[k] && cnt[k] == CW'(DB_CYCLES - 1)) db[k] <= ~db[k];
      end
    end
  // frame boundary outranks buttons in PEND so a freeze always captures a whole frame
  always_comb begin
    state_n = state;
    ret_n = ret;
    case (state)
      VIDEO:
        if (ev[2]) begin
          state_n = CLEAR;
          ret_n = VIDEO;
        end else if (ev[0]) state_n = PEND;
      PEND:
        if (vs_rise) state_n = PHOTO;
        else if (ev[2]) begin
          state_n = CLEAR;
          ret_n = VIDEO;
        end else if (ev[1]) state_n = VIDEO;
      PHOTO:
        if (ev[2]) begin
          state_n = CLEAR;
          ret_n = PHOTO;
        end else if (ev[1]) state_n = VIDEO;
      default:
        if (clr_last) state_n = ret;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= VIDEO;
      ret <= VIDEO;
      vs_prev <= 1'b0;
      clr_addr <= '0;
      DP_RAM_addr_in <= '0;
      DP_RAM_data_in <= '0;
      DP_RAM_regW <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= state_n;
      ret <= ret_n;
      vs_prev <= CAM_VSYNC;
      frame_done <= live & vs_rise;
      frame_cnt <= frame_cnt + 8'(live & vs_rise);
      DP_RAM_regW <= (state == CLEAR) | (live & cam_regW);
      if (state == CLEAR) begin
        DP_RAM_addr_in <= clr_addr;
        DP_RAM_data_in <= CLEAR_DATA;
        clr_addr <= clr_last ? '0 : clr_addr + 1'b1;
      end else if (live) begin
        DP_RAM_addr_in <= cam_addr;
        DP_RAM_data_in <= cam_data;
      end
    end
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: scenario tasks with a write scoreboard for capture_ctrl (DB_CYCLES=4, MEM_DEPTH=16)
module tb_capture_ctrl;
  localparam int AW = 15;
  logic clk = 0, rst = 1, CAM_VSYNC = 0;
  logic Photo_button = 0, Video_button = 0, Clear_button = 0, cam_regW = 0;
  logic [AW-1:0] cam_addr = '0;
  logic [11:0] cam_data = '0;
  logic [AW-1:0] DP_RAM_addr_in;
  logic [11:0] DP_RAM_data_in;
  logic DP_RAM_regW, cam_enable, frame_done;
  logic [7:0] frame_cnt;
  logic [1:0] mode;
  int total = 0, bad = 0, exp_fc = 0;
  logic [26:0] exp_q[$], got_q[$];
  capture_ctrl #(.AW(AW), .MEM_DEPTH(16), .DB_CYCLES(4), .CLEAR_DATA(12'h000)) dut (
    .clk(clk), .rst(rst), .CAM_VSYNC(CAM_VSYNC),
    .Photo_button(Photo_button), .Video_button(Video_button), .Clear_button(Clear_button),
    .cam_addr(cam_addr), .cam_data(cam_data), .cam_regW(cam_regW),
    .DP_RAM_addr_in(DP_RAM_addr_in), .DP_RAM_data_in(DP_RAM_data_in), .DP_RAM_regW(DP_RAM_regW),
    .cam_enable(cam_enable), .frame_done(frame_done), .frame_cnt(frame_cnt), .mode(mode)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (rst && DP_RAM_regW) got_q.push_back({DP_RAM_addr_in, DP_RAM_data_in});
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_mode(input logic [1:0] m, input int lim);
    for (int i = 0; i < lim && mode !== m; i++) @(negedge clk);
  endtask
  task automatic press(input logic [2:0] b, input int n);
    @(negedge clk);
    {Clear_button, Video_button, Photo_button} = b;
    repeat (n) @(negedge clk);
    {Clear_button, Video_button, Photo_button} = 3'b000;
  endtask
  task automatic push_clear();
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back({15'(i), 12'h000});
  endtask
  task automatic test_reset();
    #3 rst = 0;
    #2;
    total++;
    if (mode !== 2'd0 || cam_enable !== 1'b1) begin bad++; $display("FAIL reset_mode: got mode=%0d en=%b want mode=0 en=1", mode, cam_enable); end
    total++;
    if ({DP_RAM_addr_in, DP_RAM_data_in, DP_RAM_regW} !== 28'd0) begin bad++; $display("FAIL reset_port: got addr=%0d data=%h w=%b want 0", DP_RAM_addr_in, DP_RAM_data_in, DP_RAM_regW); end
    total++;
    if (frame_cnt !== 8'd0 || frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame: got cnt=%0d done=%b want 0", frame_cnt, frame_done); end
    idle(2);
    rst = 1;
    idle(3);
    total++;
    if (mode !== 2'd0 || DP_RAM_regW !== 1'b0) begin bad++; $display("FAIL post_reset: got mode=%0d w=%b want 0 0", mode, DP_RAM_regW); end
  endtask
  task automatic test_pass_through();
    logic [26:0] e, g;
    exp_q.delete();
    got_q.delete();
    @(negedge clk);
    cam_addr = 5;
    cam_data = 12'hABC;
    cam_regW = 1;
    exp_q.push_back({15'd5, 12'hABC});
    @(negedge clk);
    total++;
    if (DP_RAM_addr_in !== 15'd5 || DP_RAM_data_in !== 12'hABC || DP_RAM_regW !== 1'b1 || mode !== 2'd0) begin
      bad++; $display("FAIL pass_first: got addr=%0d data=%h w=%b mode=%0d want 5 abc 1 0", DP_RAM_addr_in, DP_RAM_data_in, DP_RAM_regW, mode);
    end
    for (int i = 0; i < 6; i++) begin
      cam_addr = AW'($urandom_range(0, 32767));
      cam_data = 12'($urandom);
      exp_q.push_back({cam_addr, cam_data});
      @(negedge clk);
    end
    cam_regW = 0;
    idle(2);
    while (exp_q.size() > 0) begin
      total++;
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin bad++; $display("FAIL pass_write: got none want addr=%0d data=%h", e[26:12], e[11:0]); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin bad++; $display("FAIL pass_write: got addr=%0d data=%h want addr=%0d data=%h", g[26:12], g[11:0], e[26:12], e[11:0]); end
      end
    end
    total++;
    if (got_q.size() != 0) begin bad++; $display("FAIL pass_extra: got %0d extra writes want 0", got_q.size()); end
  endtask
  task automatic test_debounce();
    press(3'b001, 3);
    idle(12);
    total++;
    if (mode !== 2'd0) begin bad++; $display("FAIL glitch: got mode=%0d want 0", mode); end
    @(negedge clk);
    Photo_button = 1;
    idle(7);
    total++;
    if (mode !== 2'd0) begin bad++; $display("FAIL press_early: got mode=%0d want 0", mode); end
    @(negedge clk);
    total++;
    if (mode !== 2'd1 || cam_enable !== 1'b1) begin bad++; $display("FAIL press_edge7: got mode=%0d en=%b want 1 1", mode, cam_enable); end
    idle(2);
    Photo_button = 0;
    idle(12);
  endtask
  task automatic test_photo_freeze();
    cam_addr = 3;
    cam_data = 12'h123;
    got_q.delete();
    @(negedge clk);
    CAM_VSYNC = 1;
    exp_fc++;
    @(negedge clk);
    total++;
    if (mode !== 2'd2 || cam_enable !== 1'b0) begin bad++; $display("FAIL freeze_mode: got mode=%0d en=%b want 2 0", mode, cam_enable); end
    total++;
    if (frame_cnt !== 8'(exp_fc) || frame_done !== 1'b1) begin bad++; $display("FAIL freeze_frame: got cnt=%0d done=%b want %0d 1", frame_cnt, frame_done, 8'(exp_fc)); end
    @(negedge clk);
    total++;
    if (frame_done !== 1'b0) begin bad++; $display("FAIL done_pulse: got %b want 0", frame_done); end
    CAM_VSYNC = 0;
    cam_regW = 1;
    cam_addr = 9;
    cam_data = 12'hFFF;
    @(negedge clk);
    CAM_VSYNC = 1;
    idle(2);
    total++;
    if (DP_RAM_regW !== 1'b0 || DP_RAM_addr_in !== 15'd3 || DP_RAM_data_in !== 12'h123) begin
      bad++; $display("FAIL freeze_hold: got addr=%0d data=%h w=%b want 3 123 0", DP_RAM_addr_in, DP_RAM_data_in, DP_RAM_regW);
    end
    total++;
    if (frame_cnt !== 8'(exp_fc) || frame_done !== 1'b0) begin bad++; $display("FAIL photo_nocount: got cnt=%0d done=%b want %0d 0", frame_cnt, frame_done, 8'(exp_fc)); end
    total++;
    if (got_q.size() != 0) begin bad++; $display("FAIL photo_dropped: got %0d writes want 0", got_q.size()); end
    CAM_VSYNC = 0;
    cam_regW = 0;
    press(3'b010, 6);
    wait_mode(2'd0, 20);
    total++;
    if (mode !== 2'd0 || cam_enable !== 1'b1) begin bad++; $display("FAIL video_resume: got mode=%0d en=%b want 0 1", mode, cam_enable); end
    got_q.delete();
    cam_addr = 11;
    cam_data = 12'h5A5;
    cam_regW = 1;
    @(negedge clk);
    cam_regW = 0;
    idle(2);
    total++;
    if (got_q.size() != 1 || got_q[0] !== {15'd11, 12'h5A5}) begin bad++; $display("FAIL resume_write: got n=%0d want one write addr=11 data=5a5", got_q.size()); end
    idle(10);
  endtask
  task automatic test_clear_from_photo();
    logic [26:0] e, g;
    press(3'b001, 6);
    wait_mode(2'd1, 20);
    @(negedge clk);
    CAM_VSYNC = 1;
    exp_fc++;
    @(negedge clk);
    CAM_VSYNC = 0;
    total++;
    if (mode !== 2'd2) begin bad++; $display("FAIL clear_pre_photo: got mode=%0d want 2", mode); end
    idle(8);
    push_clear();
    press(3'b100, 6);
    idle(2);
    total++;
    if (mode !== 2'd3 || cam_enable !== 1'b0) begin bad++; $display("FAIL clear_enter: got mode=%0d en=%b want 3 0", mode, cam_enable); end
    Photo_button = 1;
    idle(6);
    Photo_button = 0;
    wait_mode(2'd2, 40);
    total++;
    if (mode !== 2'd2) begin bad++; $display("FAIL clear_return: got mode=%0d want 2", mode); end
    @(negedge clk);
    total++;
    if (DP_RAM_regW !== 1'b0) begin bad++; $display("FAIL clear_stop: got w=%b want 0", DP_RAM_regW); end
    while (exp_q.size() > 0) begin
      total++;
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin bad++; $display("FAIL clear_write: got none want addr=%0d data=%h", e[26:12], e[11:0]); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin bad++; $display("FAIL clear_write: got addr=%0d data=%h want addr=%0d data=%h", g[26:12], g[11:0], e[26:12], e[11:0]); end
      end
    end
    total++;
    if (got_q.size() != 0) begin bad++; $display("FAIL clear_extra: got %0d extra writes want 0", got_q.size()); end
    idle(10);
    total++;
    if (mode !== 2'd2) begin bad++; $display("FAIL clear_photo_ignored: got mode=%0d want 2", mode); end
    press(3'b010, 6);
    wait_mode(2'd0, 20);
    idle(10);
  endtask
  task automatic test_simultaneous();
    logic [26:0] e, g;
    push_clear();
    press(3'b101, 6);
    idle(2);
    total++;
    if (mode !== 2'd3) begin bad++; $display("FAIL clear_over_photo: got mode=%0d want 3", mode); end
    wait_mode(2'd0, 40);
    idle(2);
    while (exp_q.size() > 0) begin
      total++;
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin bad++; $display("FAIL sim_write: got none want addr=%0d data=%h", e[26:12], e[11:0]); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin bad++; $display("FAIL sim_write: got addr=%0d data=%h want addr=%0d data=%h", g[26:12], g[11:0], e[26:12], e[11:0]); end
      end
    end
    total++;
    if (got_q.size() != 0 || mode !== 2'd0) begin bad++; $display("FAIL sim_after: got extra=%0d mode=%0d want 0 0", got_q.size(), mode); end
    idle(8);
    press(3'b001, 6);
    wait_mode(2'd1, 20);
    idle(8);
    press(3'b010, 6);
    @(negedge clk);
    CAM_VSYNC = 1;
    exp_fc++;
    @(negedge clk);
    total++;
    if (mode !== 2'd2 || frame_cnt !== 8'(exp_fc)) begin bad++; $display("FAIL vs_over_video: got mode=%0d cnt=%0d want 2 %0d", mode, frame_cnt, 8'(exp_fc)); end
    CAM_VSYNC = 0;
    idle(10);
    press(3'b010, 6);
    wait_mode(2'd0, 20);
    idle(10);
  endtask
  task automatic test_reset_mid_clear();
    logic [26:0] e, g;
    press(3'b100, 6);
    wait_mode(2'd3, 20);
    for (int i = 0; i < 20 && !(DP_RAM_regW === 1'b1 && DP_RAM_addr_in === 15'd6); i++) @(negedge clk);
    total++;
    if (DP_RAM_addr_in !== 15'd6 || mode !== 2'd3) begin bad++; $display("FAIL mid_clear_reach: got addr=%0d mode=%0d want 6 3", DP_RAM_addr_in, mode); end
    rst = 0;
    exp_fc = 0;
    #1;
    total++;
    if (mode !== 2'd0 || cam_enable !== 1'b1 || {DP_RAM_addr_in, DP_RAM_data_in, DP_RAM_regW} !== 28'd0 || frame_cnt !== 8'd0) begin
      bad++; $display("FAIL async_reset: got mode=%0d en=%b addr=%0d data=%h w=%b cnt=%0d want 0 1 0 0 0 0", mode, cam_enable, DP_RAM_addr_in, DP_RAM_data_in, DP_RAM_regW, frame_cnt);
    end
    @(negedge clk);
    rst = 1;
    idle(8);
    push_clear();
    press(3'b100, 6);
    wait_mode(2'd3, 20);
    wait_mode(2'd0, 40);
    idle(2);
    while (exp_q.size() > 0) begin
      total++;
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin bad++; $display("FAIL restart_write: got none want addr=%0d data=%h", e[26:12], e[11:0]); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin bad++; $display("FAIL restart_write: got addr=%0d data=%h want addr=%0d data=%h", g[26:12], g[11:0], e[26:12], e[11:0]); end
      end
    end
    total++;
    if (got_q.size() != 0) begin bad++; $display("FAIL restart_extra: got %0d extra writes want 0", got_q.size()); end
    idle(10);
  endtask
  task automatic test_frame_wrap();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      CAM_VSYNC = 1;
      @(negedge clk);
      exp_fc++;
      if (i == 0) begin
        total++;
        if (frame_done !== 1'b1) begin bad++; $display("FAIL wrap_done: got %b want 1", frame_done); end
      end
      if (i == 254) begin
        total++;
        if (frame_cnt !== 8'd255) begin bad++; $display("FAIL wrap_255: got %0d want 255", frame_cnt); end
      end
      CAM_VSYNC = 0;
    end
    @(negedge clk);
    total++;
    if (frame_cnt !== 8'(exp_fc) || frame_cnt !== 8'd0 || mode !== 2'd0) begin bad++; $display("FAIL wrap_zero: got cnt=%0d mode=%0d want 0 0", frame_cnt, mode); end
  endtask
  initial begin
    test_reset();
    test_pass_through();
    test_debounce();
    test_photo_freeze();
    test_clear_from_photo();
    test_simultaneous();
    test_reset_mid_clear();
    test_frame_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
